// File: rtl/decode_stage.sv
// ID stage of the 5-stage RV32I pipeline: register file, field decode, immediate
// generation, load-use stall detection and the registered ID/EX bundle.
module decode_stage #(
    parameter int          PC_W     = 12,
    parameter int          XLEN     = 32,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     d_inst,
    input  logic [PC_W-1:0] d_pc,
    input  logic            d_valid,
    input  logic            d_flush,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            d_pcwr,
    output logic            ex_valid,
    output logic [PC_W-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [6:0]      ex_opcode,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7b5,
    output logic            ex_memrd,
    output logic            ex_memwr,
    output logic            ex_regwr
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic [XLEN-1:0] r_regs [0:31];

    logic [6:0]      w_opcode;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;
    logic [31:0]     w_imm32;
    logic            w_rs1_used;
    logic            w_rs2_used;
    logic            w_writes_rd;
    logic            w_id_valid;
    logic            w_hazard;
    logic            w_bubble;
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;

    assign w_opcode = d_inst[6:0];
    assign w_rd     = d_inst[11:7];
    assign w_rs1    = d_inst[19:15];
    assign w_rs2    = d_inst[24:20];

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_imm32 = '0;
        case (w_opcode)
            OPC_LOAD, OPC_OPIMM, OPC_JALR:
                w_imm32 = {{20{d_inst[31]}}, d_inst[31:20]};
            OPC_STORE:
                w_imm32 = {{20{d_inst[31]}}, d_inst[31:25], d_inst[11:7]};
            OPC_BRANCH:
                w_imm32 = {{20{d_inst[31]}}, d_inst[7], d_inst[30:25], d_inst[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                w_imm32 = {d_inst[31:12], 12'b0};
            OPC_JAL:
                w_imm32 = {{12{d_inst[31]}}, d_inst[19:12], d_inst[20], d_inst[30:21], 1'b0};
            default:
                w_imm32 = '0;
        endcase
    end

    always_comb begin
        w_writes_rd = 1'b0;
        case (w_opcode)
            OPC_LOAD, OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR:
                w_writes_rd = (w_rd != 5'd0);
            default:
                w_writes_rd = 1'b0;
        endcase
    end

    assign w_rs1_used = !((w_opcode == OPC_LUI) || (w_opcode == OPC_AUIPC) || (w_opcode == OPC_JAL));
    assign w_rs2_used = (w_opcode == OPC_OP) || (w_opcode == OPC_STORE) || (w_opcode == OPC_BRANCH);

    assign w_id_valid = d_valid && (d_inst != NOP_INST);

    // Load in EX whose result the ID instruction needs: hold fetch, insert one bubble.
    assign w_hazard = ex_valid && ex_memrd && (ex_rd != 5'd0) && w_id_valid &&
                      ((w_rs1_used && (ex_rd == w_rs1)) || (w_rs2_used && (ex_rd == w_rs2)));

    assign d_pcwr   = w_hazard && !d_flush;
    assign w_bubble = d_flush || !w_id_valid || w_hazard;

    // x0 is never written, so its entry stays zero and needs no read-side special case.
    assign w_rs1_data = (wb_we && (wb_rd != 5'd0) && (wb_rd == w_rs1)) ? wb_data : r_regs[w_rs1];
    assign w_rs2_data = (wb_we && (wb_rd != 5'd0) && (wb_rd == w_rs2)) ? wb_data : r_regs[w_rs2];

    // NOTE: this memory is deliberately reset; a cleared register file is part of the reset state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_we && (wb_rd != 5'd0)) begin
            r_regs[wb_rd] <= wb_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_opcode   <= '0;
            ex_funct3   <= '0;
            ex_funct7b5 <= 1'b0;
            ex_memrd    <= 1'b0;
            ex_memwr    <= 1'b0;
            ex_regwr    <= 1'b0;
        end else begin
            ex_pc       <= d_pc;
            ex_rs1_data <= w_rs1_data;
            ex_rs2_data <= w_rs2_data;
            ex_imm      <= XLEN'($signed(w_imm32));
            ex_rs1      <= w_rs1;
            ex_rs2      <= w_rs2;
            ex_rd       <= w_rd;
            ex_opcode   <= w_opcode;
            ex_funct3   <= d_inst[14:12];
            ex_funct7b5 <= d_inst[30];
            if (w_bubble) begin
                ex_valid <= 1'b0;
                ex_memrd <= 1'b0;
                ex_memwr <= 1'b0;
                ex_regwr <= 1'b0;
            end else begin
                ex_valid <= 1'b1;
                ex_memrd <= (w_opcode == OPC_LOAD);
                ex_memwr <= (w_opcode == OPC_STORE);
                ex_regwr <= w_writes_rd;
            end
        end
    end

endmodule
